// File: rtl/clk_switch_monitor.sv
// clk_switch_monitor
// Observes the output of the glitch-free clock switch by sampling it as data
// on a fast free-running clock. Every completed high/low phase is measured and
// classified; a small FSM locks onto source A (fast) or B (slow), and flags
// runt phases, a stopped output and A<->B changeovers. All status is in the
// clk domain, so a status register can read it without a CDC.
module clk_switch_monitor #(
    parameter int CNT_W      = 8,
    parameter int A_HALF_MIN = 4,
    parameter int A_HALF_MAX = 6,
    parameter int B_HALF_MIN = 9,
    parameter int B_HALF_MAX = 11,
    parameter int GLITCH_MAX = 2,
    parameter int STOP_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             en,
    input  logic             clr,
    output logic [1:0]       src,
    output logic             switch_pulse,
    output logic             glitch_pulse,
    output logic             glitch,
    output logic             stopped,
    output logic [CNT_W-1:0] last_width,
    output logic [7:0]       switch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_ACQ,
        S_LOCK_A,
        S_LOCK_B,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        PH_GLITCH,
        PH_A,
        PH_B,
        PH_STRETCH
    } phase_t;

    // Source class encoding doubles as the src output encoding.
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_A    = 2'd1;
    localparam logic [1:0] CLS_B    = 2'd2;

    localparam logic [CNT_W-1:0] W_GLITCH = CNT_W'(GLITCH_MAX);
    localparam logic [CNT_W-1:0] W_A_MIN  = CNT_W'(A_HALF_MIN);
    localparam logic [CNT_W-1:0] W_A_MAX  = CNT_W'(A_HALF_MAX);
    localparam logic [CNT_W-1:0] W_B_MIN  = CNT_W'(B_HALF_MIN);
    localparam logic [CNT_W-1:0] W_B_MAX  = CNT_W'(B_HALF_MAX);
    localparam logic [CNT_W-1:0] W_STOP   = CNT_W'(STOP_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    // Anything that is neither a runt nor a legal half-period is a stretch,
    // which the switch produces while it holds the output low in a changeover.
    function automatic phase_t classify(input logic [CNT_W-1:0] w);
        if (w <= W_GLITCH)                return PH_GLITCH;
        if (w >= W_A_MIN && w <= W_A_MAX) return PH_A;
        if (w >= W_B_MIN && w <= W_B_MAX) return PH_B;
        return PH_STRETCH;
    endfunction

    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    state_t           state_q, state_d;
    logic [1:0]       acq_prev_q, acq_prev_d;
    logic [1:0]       last_locked_q, last_locked_d;

    logic [1:0]       src_q, src_d;
    logic             switch_pulse_q, switch_pulse_d;
    logic             glitch_pulse_q, glitch_pulse_d;
    logic             glitch_q, glitch_d;
    logic             stopped_q, stopped_d;
    logic [CNT_W-1:0] last_width_q, last_width_d;
    logic [7:0]       switch_cnt_q, switch_cnt_d;

    logic             edge_det;
    logic             stop_hit;
    phase_t           phase;
    phase_t           own_phase;
    logic [1:0]       phase_cls;
    logic             glitch_ev;
    logic             lock_ev;
    logic             switch_ev;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge value of its neighbour, which is what makes this a
            // shift chain rather than a single wire.
            sync1_q <= mon_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_det  = sync2_q ^ hist_q;
    assign stop_hit  = (run_cnt_q == W_STOP);
    assign phase     = classify(run_cnt_q);
    assign own_phase = (state_q == S_LOCK_A) ? PH_A : PH_B;
    assign phase_cls = (phase == PH_A) ? CLS_A :
                       (phase == PH_B) ? CLS_B : CLS_NONE;

    // Phase width counter: restarts at 1 on each edge, saturates, cleared while disabled.
    always_comb begin
        if (!en) begin
            run_cnt_d = '0;
        end else if (edge_det) begin
            run_cnt_d = CNT_ONE;
        end else if (run_cnt_q != CNT_SAT) begin
            run_cnt_d = run_cnt_q + CNT_ONE;
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Width counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_cnt_q <= '0;
        else     run_cnt_q <= run_cnt_d;
    end

    // FSM state register, including the pending-pair class used in ACQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acq_prev_q    <= CLS_NONE;
            last_locked_q <= CLS_NONE;
        end else begin
            state_q       <= state_d;
            acq_prev_q    <= acq_prev_d;
            last_locked_q <= last_locked_d;
        end
    end

    // FSM next-state logic: edges are judged by the completed width; a
    // same-cycle edge takes precedence over the stop limit.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        acq_prev_d = acq_prev_q;
        glitch_ev  = 1'b0;
        lock_ev    = 1'b0;
        if (!en) begin
            state_d    = S_IDLE;
            acq_prev_d = CLS_NONE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_SKIP;
                S_SKIP: begin
                    if (edge_det) begin
                        state_d    = S_ACQ;
                        acq_prev_d = CLS_NONE;
                    end else if (stop_hit) begin
                        state_d = S_STOP;
                    end
                end
                S_ACQ: begin
                    if (edge_det) begin
                        glitch_ev = (phase == PH_GLITCH);
                        if (phase_cls != CLS_NONE && phase_cls == acq_prev_q) begin
                            lock_ev    = 1'b1;
                            state_d    = (phase_cls == CLS_A) ? S_LOCK_A : S_LOCK_B;
                            acq_prev_d = CLS_NONE;
                        end else begin
                            acq_prev_d = phase_cls;
                        end
                    end else if (stop_hit) begin
                        state_d = S_STOP;
                    end
                end
                S_LOCK_A, S_LOCK_B: begin
                    if (edge_det) begin
                        if (phase != own_phase) begin
                            glitch_ev  = (phase == PH_GLITCH);
                            state_d    = S_ACQ;
                            acq_prev_d = CLS_NONE;
                        end
                    end else if (stop_hit) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (edge_det) state_d = S_SKIP;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: next values of every registered status output.
    always_comb begin
        src_d          = (state_d == S_LOCK_A) ? CLS_A :
                         (state_d == S_LOCK_B) ? CLS_B : CLS_NONE;
        stopped_d      = (state_d == S_STOP);
        switch_ev      = lock_ev && (last_locked_q != CLS_NONE) &&
                         (last_locked_q != phase_cls);
        switch_pulse_d = switch_ev;
        glitch_pulse_d = glitch_ev;
        last_locked_d  = lock_ev ? phase_cls : last_locked_q;
        last_width_d   = (en && edge_det) ? run_cnt_q : last_width_q;
        // A clear wins over a same-cycle set or increment.
        glitch_d       = clr ? 1'b0 : (glitch_q | glitch_ev);
        switch_cnt_d   = clr ? 8'd0 : (switch_cnt_q + {7'd0, switch_ev});
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q          <= CLS_NONE;
            switch_pulse_q <= 1'b0;
            glitch_pulse_q <= 1'b0;
            glitch_q       <= 1'b0;
            stopped_q      <= 1'b0;
            last_width_q   <= '0;
            switch_cnt_q   <= 8'd0;
        end else begin
            src_q          <= src_d;
            switch_pulse_q <= switch_pulse_d;
            glitch_pulse_q <= glitch_pulse_d;
            glitch_q       <= glitch_d;
            stopped_q      <= stopped_d;
            last_width_q   <= last_width_d;
            switch_cnt_q   <= switch_cnt_d;
        end
    end

    assign src          = src_q;
    assign switch_pulse = switch_pulse_q;
    assign glitch_pulse = glitch_pulse_q;
    assign glitch       = glitch_q;
    assign stopped      = stopped_q;
    assign last_width   = last_width_q;
    assign switch_cnt   = switch_cnt_q;

endmodule

// File: tb/tb_clk_switch_monitor.sv
// Testbench for clk_switch_monitor: directed scenarios followed by randomized
// phase streams, all compared every cycle against a phase-level reference model.
`timescale 1ns/1ps
module tb_clk_switch_monitor;

    localparam int CNT_W      = 8;
    localparam int A_MIN      = 4;
    localparam int A_MAX      = 6;
    localparam int B_MIN      = 9;
    localparam int B_MAX      = 11;
    localparam int GLITCH_MAX = 2;
    localparam int STOP_LIMIT = 64;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mon_clk = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic [1:0]       src;
    logic             switch_pulse;
    logic             glitch_pulse;
    logic             glitch;
    logic             stopped;
    logic [CNT_W-1:0] last_width;
    logic [7:0]       switch_cnt;

    clk_switch_monitor #(
        .CNT_W(CNT_W), .A_HALF_MIN(A_MIN), .A_HALF_MAX(A_MAX),
        .B_HALF_MIN(B_MIN), .B_HALF_MAX(B_MAX),
        .GLITCH_MAX(GLITCH_MAX), .STOP_LIMIT(STOP_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .mon_clk(mon_clk), .en(en), .clr(clr),
        .src(src), .switch_pulse(switch_pulse), .glitch_pulse(glitch_pulse),
        .glitch(glitch), .stopped(stopped), .last_width(last_width),
        .switch_cnt(switch_cnt)
    );

    always #0.5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model (phase level) ----------------
    typedef enum {M_OFF, M_DISCARD, M_HUNT, M_LOCKED, M_STALL} mode_e;
    mode_e mode;
    int    locked_cls;     // 1 = A, 2 = B
    int    streak_cls;     // class of the run of equal legal phases seen while hunting
    int    streak_len;
    int    prev_lock;      // 0 = never locked
    int    phase_len;      // cycles since last seen edge
    bit    samples[$];     // samples[k] = mon_clk sampled k+1 clocks ago
    int    m_lw, m_sw;
    bit    m_flag, m_gp, m_sp;

    // 0 = runt, 1 = A, 2 = B, 3 = stretch
    function automatic int classify(input int w);
        if (w <= GLITCH_MAX) return 0;
        if (w >= A_MIN && w <= A_MAX) return 1;
        if (w >= B_MIN && w <= B_MAX) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        mode = M_OFF; locked_cls = 0; streak_cls = 0; streak_len = 0;
        prev_lock = 0; phase_len = 0;
        samples = '{1'b0, 1'b0, 1'b0};
        m_lw = 0; m_sw = 0; m_flag = 1'b0; m_gp = 1'b0; m_sp = 1'b0;
    endtask

    task automatic take_lock(input int c);
        if (prev_lock != 0 && prev_lock != c) begin
            m_sp = 1'b1;
            m_sw = (m_sw + 1) % 256;
        end
        prev_lock  = c;
        locked_cls = c;
        mode       = M_LOCKED;
    endtask

    task automatic model_step(input bit mon_now, input bit en_now, input bit clr_now);
        bit e;
        int w;
        int c;
        e = (samples[1] != samples[2]);   // synchronized value vs history
        w = phase_len;
        c = classify(w);
        m_gp = 1'b0;
        m_sp = 1'b0;
        if (!en_now) begin
            mode = M_OFF;
        end else begin
            if (e) m_lw = w;
            case (mode)
                M_OFF: mode = M_DISCARD;
                M_DISCARD: begin
                    if (e) begin mode = M_HUNT; streak_len = 0; end
                    else if (w == STOP_LIMIT) mode = M_STALL;
                end
                M_HUNT: begin
                    if (e) begin
                        if (c == 1 || c == 2) begin
                            if (streak_len > 0 && streak_cls == c) streak_len++;
                            else begin streak_cls = c; streak_len = 1; end
                            if (streak_len == 2) take_lock(c);
                        end else begin
                            streak_len = 0;
                            if (c == 0) begin m_gp = 1'b1; m_flag = 1'b1; end
                        end
                    end else if (w == STOP_LIMIT) mode = M_STALL;
                end
                M_LOCKED: begin
                    if (e) begin
                        if (c != locked_cls) begin
                            mode = M_HUNT;
                            streak_len = 0;
                            if (c == 0) begin m_gp = 1'b1; m_flag = 1'b1; end
                        end
                    end else if (w == STOP_LIMIT) mode = M_STALL;
                end
                M_STALL: if (e) mode = M_DISCARD;
                default: mode = M_OFF;
            endcase
        end
        if (clr_now) begin m_flag = 1'b0; m_sw = 0; end
        if (!en_now)             phase_len = 0;
        else if (e)              phase_len = 1;
        else if (phase_len < SAT) phase_len = phase_len + 1;
        samples.push_front(mon_now);
        void'(samples.pop_back());
    endtask

    task automatic compare_all();
        check("src",          src,          (mode == M_LOCKED) ? locked_cls : 0);
        check("switch_pulse", switch_pulse, m_sp);
        check("glitch_pulse", glitch_pulse, m_gp);
        check("glitch",       glitch,       m_flag);
        check("stopped",      stopped,      (mode == M_STALL) ? 1 : 0);
        check("last_width",   last_width,   m_lw);
        check("switch_cnt",   switch_cnt,   m_sw);
    endtask

    // ---------------- stimulus helpers ----------------
    bit en_v     = 1'b0;
    bit rst_v    = 1'b1;
    bit rand_clr = 1'b0;
    int gp_seen  = 0;

    task automatic tick(input bit m, input bit e, input bit c);
        @(negedge clk);
        rst = rst_v; mon_clk = m; en = e; clr = c;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(m, e, c);
        #0.2;
        compare_all();
        if (glitch_pulse) gp_seen++;
    endtask

    task automatic run_phase(input bit level, input int width);
        repeat (width) tick(level, en_v, rand_clr ? ($urandom_range(99) < 2) : 1'b0);
    endtask

    task automatic square(input int half, input int n_phases);
        for (int i = 0; i < n_phases; i++) run_phase(!mon_clk, half);
    endtask

    task automatic random_burst();
        int kind;
        int n;
        int w;
        kind = $urandom_range(99);
        if (kind < 35) begin
            n = $urandom_range(2, 8);
            repeat (n) run_phase(!mon_clk, $urandom_range(A_MIN, A_MAX));
        end else if (kind < 70) begin
            n = $urandom_range(2, 8);
            repeat (n) run_phase(!mon_clk, $urandom_range(B_MIN, B_MAX));
        end else if (kind < 80) begin
            run_phase(!mon_clk, $urandom_range(1, GLITCH_MAX));
        end else if (kind < 90) begin
            case ($urandom_range(0, 3))
                0:       w = 3;
                1:       w = 7;
                2:       w = 8;
                default: w = $urandom_range(12, 40);
            endcase
            run_phase(!mon_clk, w);
        end else if (kind < 94) begin
            run_phase(!mon_clk, $urandom_range(60, 90));
        end else begin
            en_v = 1'b0;
            n = $urandom_range(1, 10);
            repeat (n) tick(mon_clk, en_v, 1'b0);
            en_v = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        #0.2;
        // Reset values while rst is held.
        check("rst_src",        src,          0);
        check("rst_glitch",     glitch,       0);
        check("rst_stopped",    stopped,      0);
        check("rst_last_width", last_width,   0);
        check("rst_switch_cnt", switch_cnt,   0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        rst_v = 1'b0;
        en_v  = 1'b1;

        // 10 ns square wave locks to A.
        square(5, 20);
        check("a_src",        src,        1);
        check("a_last_width", last_width, 5);
        check("a_glitch",     glitch,     0);
        check("a_switch_cnt", switch_cnt, 0);

        // Changeover A -> B through a 15-cycle low stretch.
        run_phase(1'b1, 5);
        run_phase(1'b0, 15);
        square(10, 20);
        check("ab_src",        src,        2);
        check("ab_switch_cnt", switch_cnt, 1);
        check("ab_glitch",     glitch,     0);

        // Back to A, then a 2-cycle runt high pulse.
        square(5, 10);
        gp_seen = 0;
        run_phase(1'b1, 5);
        run_phase(1'b0, 3);
        run_phase(1'b1, 2);
        run_phase(1'b0, 5);
        square(5, 10);
        check("runt_pulses", gp_seen, 1);
        check("runt_glitch", glitch,  1);
        check("runt_src",    src,     1);

        // Stopped output, then restart at 20 ns.
        run_phase(1'b1, 5);
        run_phase(1'b0, 100);
        check("stop_stopped", stopped, 1);
        check("stop_src",     src,     0);
        square(10, 20);
        check("restart_stopped", stopped, 0);
        check("restart_src",     src,     2);

        // clr in the same cycle as a detected runt.
        run_phase(1'b1, 10);
        run_phase(1'b0, 3);
        run_phase(1'b1, 2);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("clr_gp",         glitch_pulse, 1);
        check("clr_glitch",     glitch,       0);
        check("clr_switch_cnt", switch_cnt,   0);
        tick(1'b0, 1'b1, 1'b0);
        check("clr_glitch_hold", glitch, 0);
        run_phase(1'b0, 4);
        square(10, 10);

        // Asynchronous reset while locked to A.
        square(5, 10);
        @(posedge clk);
        #0.3;
        rst = 1'b1;
        rst_v = 1'b1;
        #0.1;
        model_reset();
        check("arst_src",        src,          0);
        check("arst_sp",         switch_pulse, 0);
        check("arst_gp",         glitch_pulse, 0);
        check("arst_glitch",     glitch,       0);
        check("arst_stopped",    stopped,      0);
        check("arst_last_width", last_width,   0);
        check("arst_switch_cnt", switch_cnt,   0);
        repeat (3) tick(mon_clk, 1'b1, 1'b0);
        rst_v = 1'b0;
        square(5, 10);
        check("relock_src", src, 1);

        // Many A<->B changeovers so the changeover count wraps.
        for (int i = 0; i < 140; i++) begin
            square(10, 3);
            square(5, 3);
        end

        // Randomized phase streams with occasional clr and enable drops.
        rand_clr = 1'b1;
        for (int i = 0; i < 400; i++) random_burst();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_switch_monitor.md
# clk_switch_monitor

Observer-side companion to the glitch-free clock switch: samples the switch output `mon_clk` as data on a fast free-running sampling clock, measures every high and low phase, and reports which source (A = fast, B = slow) is driving it. It also flags glitches (runt phases), stopped output and A<->B changeovers, and counts changeovers. It sits in the clock-mux test/diagnostic path and lets a bench or a status register check the switch without a clock-domain crossing on the status side.

## Interface
- `CNT_W`, 8: phase-width counter width; saturates at 2^CNT_W-1
- `A_HALF_MIN`, 4 / `A_HALF_MAX`, 6: legal half-period range of source A, in `clk` cycles
- `B_HALF_MIN`, 9 / `B_HALF_MAX`, 11: legal half-period range of source B; ranges must not overlap
- `GLITCH_MAX`, 2: phase width <= this is a glitch
- `STOP_LIMIT`, 64: cycles without an edge that declare the output stopped; < 2^CNT_W-1
- `clk`  in  1  sampling clock, must be at least 4x faster than source A
- `rst`  in  1  asynchronous reset, active-high
- `mon_clk`  in  1  observed switch output; asynchronous to `clk`
- `en`  in  1  monitor enable
- `clr`  in  1  clears `glitch` and `switch_cnt`
- `src`  out  2  0 = none/stopped, 1 = A, 2 = B
- `switch_pulse`  out  1  one-cycle pulse on a lock to a class different from the previous lock
- `glitch_pulse`  out  1  one-cycle pulse per glitch phase
- `glitch`  out  1  sticky glitch flag
- `stopped`  out  1  level, no edge for STOP_LIMIT cycles
- `last_width`  out  CNT_W  width of the most recently completed phase
- `switch_cnt`  out  8  changeover count, wraps 255 -> 0

## Operation
- `mon_clk` passes through a 2-flop synchronizer (reset 0). An edge is a change between sync stage 2 and a third history flop.
- Width counter `run_cnt`: on an edge cycle it loads 1; otherwise it increments, saturating. On an edge, the completed width w = `run_cnt` before the load.
- Classification of w: GLITCH if w <= GLITCH_MAX; A if within the A range; B if within the B range; otherwise STRETCH, which is legal because the switch holds the output low during a changeover.
- FSM states: IDLE, SKIP, ACQ, LOCK_A, LOCK_B, STOP. Reset state is IDLE.
- IDLE: `src`=0. When `en`=1, go to SKIP.
- SKIP: discard the first edge (the partial phase), then go to ACQ.
- ACQ: `src`=0. Two consecutive phases of the same class A (or B) go to LOCK_A (LOCK_B). Any other class restarts the pair.
- LOCK_x: `src`=x. A phase of class x stays. STRETCH or the other class goes to ACQ, with no flag.
- GLITCH from any state except IDLE/SKIP: `glitch_pulse`, `glitch`<=1, go to ACQ.
- From any state except IDLE: if `run_cnt` reaches STOP_LIMIT, go to STOP. STOP sets `stopped`=1 and `src`=0. The next edge goes to SKIP and clears `stopped`.
- `last_locked` (reset none) records the class of each entry into LOCK. If the new lock class differs from `last_locked` and `last_locked` is not none: `switch_pulse`, `switch_cnt`+1.
- `en`=0 forces IDLE in the next cycle and clears `run_cnt`. `glitch`, `switch_cnt` and `last_locked` hold.
- `clr` wins over a same-cycle glitch set or count increment: the result is 0.

## Timing
- Reset values: `src`=0, `switch_pulse`=0, `glitch_pulse`=0, `glitch`=0, `stopped`=0, `last_width`=0, `switch_cnt`=0. The FSM is in IDLE and all sync/history flops are 0.
- All outputs are registered. An edge detected in cycle N updates `last_width`, `src` and the pulses at N+1.
- Latency from a `mon_clk` transition to edge detection is 2-3 `clk` cycles.
- `stopped` asserts at the cycle after `run_cnt`==STOP_LIMIT.
- Pulses are exactly one cycle wide, including back-to-back events.

## Test plan
- `clk` 1 ns, `mon_clk` = 10 ns square wave, `en`=1 after reset -> `src`=1 within 3 phases; `last_width`=5; no pulses.
- `mon_clk` changes from 10 ns to 20 ns via a 15-cycle low stretch -> one passage through ACQ, then `src`=2, `switch_pulse` once, `switch_cnt`=1, `glitch`=0.
- A 2 ns runt high pulse injected while locked to A -> `glitch_pulse` once, `glitch`=1, `src`=0 until relock, then `src`=1.
- `mon_clk` held low for 100 cycles -> `stopped`=1 and `src`=0 exactly 64 cycles after the last edge. Restart at 20 ns -> `stopped`=0, `src`=2.
- `clr` asserted in the same cycle as a glitch -> `glitch`=0 and `switch_cnt`=0 after that cycle.
- Async `rst` mid-lock, then release -> all outputs at reset values; relock requires SKIP plus two phases.
